axi_wpack: RTL and testbench

Write-side packer that sits directly upstream of the asynchronous FIFO write port, in the WClk domain. It accepts narrow AXI-style write-data beats over a valid/ready handshake and packs RATIO consecutive beats into one wide FIFO word of data, byte strobes and a last flag. It drives the FIFO's we and d inputs and obeys its wfull backpressure. A burst's final beat always closes its word, so burst boundaries never share a FIFO entry.

---
 rtl/axi_wpack_if.sv | 19 +
 rtl/axi_wpack.sv | 63 ++++++
 tb/tb_axi_wpack.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/axi_wpack_if.sv
// axi_wpack_if: narrow write-beat handshake plus FIFO write-port signals for axi_wpack.
interface axi_wpack_if #(
   parameter int IW    = 32,
   parameter int RATIO = 4
);
   localparam int FW = RATIO*IW + RATIO*IW/8 + 1;
   logic            s_valid;
   logic            s_ready;
   logic [IW-1:0]   s_data;
   logic [IW/8-1:0] s_strb;
   logic            s_last;
   logic            fifo_we;
   logic            fifo_wfull;
   logic [FW-1:0]   fifo_d;
   modport master (output s_valid, s_data, s_strb, s_last, fifo_wfull,
                   input  s_ready, fifo_we, fifo_d);
   modport slave  (input  s_valid, s_data, s_strb, s_last, fifo_wfull,
                   output s_ready, fifo_we, fifo_d);
endinterface

// File: rtl/axi_wpack.sv
// axi_wpack: packs RATIO narrow beats (or a shorter burst tail) into one wide async-FIFO word.
module axi_wpack #(
   parameter int IW    = 32,
   parameter int RATIO = 4
) (
   input  logic        WClk,
   input  logic        rstn,
   axi_wpack_if.slave  bus,
   output logic [15:0] words_out_o,
   output logic        busy_o
);
   localparam int LW = $clog2(RATIO);
   localparam int SW = IW/8;
   localparam int DW = RATIO*IW;
   localparam int BW = RATIO*SW;
   localparam int FW = DW + BW + 1;
   logic [LW-1:0] lane_q, lane_d;
   logic [DW-1:0] data_q, data_d, data_m;
   logic [BW-1:0] strb_q, strb_d, strb_m;
   logic [FW-1:0] hold_q, hold_d;
   logic          ov_q, ov_d;
   logic [15:0]   words_q, words_d;
   logic          accept, done;
   assign bus.s_ready = ~ov_q | ~bus.fifo_wfull;
   assign bus.fifo_we = ov_q & ~bus.fifo_wfull;
   assign bus.fifo_d  = hold_q;
   assign words_out_o = words_q;
   assign busy_o      = ov_q | (lane_q != '0);
   always_comb begin
      accept = bus.s_valid & bus.s_ready;
      done   = accept & (bus.s_last | (lane_q == LW'(RATIO-1)));
      data_m = data_q;
      strb_m = strb_q;
      for (int k = 0; k < RATIO; k++)
         if (lane_q == LW'(k)) begin
            data_m[k*IW +: IW] = bus.s_data;
            strb_m[k*SW +: SW] = bus.s_strb;
         end
      data_d  = done ? '0 : accept ? data_m : data_q;
      strb_d  = done ? '0 : accept ? strb_m : strb_q;
      lane_d  = done ? '0 : accept ? lane_q + LW'(1) : lane_q;
      hold_d  = done ? {bus.s_last, strb_m, data_m} : hold_q;
      // a completion in the draining cycle reloads the holder, so valid stays up
      ov_d    = done | (ov_q & ~bus.fifo_we);
      words_d = words_q + 16'(bus.fifo_we);
   end
   always_ff @(posedge WClk or negedge rstn)
      if (!rstn) begin
         lane_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         hold_q  <= '0;
         ov_q    <= 1'b0;
         words_q <= '0;
      end else begin
         lane_q  <= lane_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         hold_q  <= hold_d;
         ov_q    <= ov_d;
         words_q <= words_d;
      end
endmodule

// File: tb/tb_axi_wpack.sv
// tb_axi_wpack: randomized scoreboard bench; a beat-list model builds expected FIFO words.
module tb_axi_wpack;
   localparam int IW    = 32;
   localparam int RATIO = 4;
   localparam int SW    = IW/8;
   localparam int FW    = RATIO*IW + RATIO*SW + 1;
   logic        WClk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] words_out;
   logic        busy;
   int          chk_cnt = 0;
   int          pass_cnt = 0;
   int          cyc = 0;
   logic [FW-1:0] exp_q[$];
   logic [IW-1:0] cur_d[$];
   logic [SW-1:0] cur_s[$];
   int            wr_cyc[$];
   logic [15:0]   exp_words = '0;
   axi_wpack_if #(.IW(IW), .RATIO(RATIO)) bus ();
   axi_wpack #(.IW(IW), .RATIO(RATIO)) dut (
      .WClk(WClk), .rstn(rstn), .bus(bus), .words_out_o(words_out), .busy_o(busy)
   );
   always #5 WClk = ~WClk;
   always @(posedge WClk) cyc++;
   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   // reference: a word is the list of beats since the last word, zero-padded, tagged with last
   task automatic model_beat(input logic [IW-1:0] d, input logic [SW-1:0] s, input logic l);
      logic [FW-1:0] w;
      cur_d.push_back(d);
      cur_s.push_back(s);
      if (cur_d.size() == RATIO || l) begin
         w = '0;
         foreach (cur_d[i]) begin
            w[i*IW +: IW]            = cur_d[i];
            w[RATIO*IW + i*SW +: SW] = cur_s[i];
         end
         w[FW-1] = l;
         exp_q.push_back(w);
         exp_words++;
         cur_d.delete();
         cur_s.delete();
      end
   endtask
   always @(negedge WClk)
      if (rstn && bus.fifo_we) begin
         wr_cyc.push_back(cyc);
         chk("we_while_full", FW'(bus.fifo_wfull), FW'(0));
         if (exp_q.size() == 0) chk("unexpected_write", FW'(1), FW'(0));
         else chk("word", bus.fifo_d, exp_q.pop_front());
      end
   task automatic send_beat(input logic [IW-1:0] d, input logic [SW-1:0] s, input logic l, output int stalls);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_strb  = s;
      bus.s_last  = l;
      stalls = 0;
      @(negedge WClk);
      while (!bus.s_ready && stalls < 200) begin
         stalls++;
         @(negedge WClk);
      end
      if (!bus.s_ready) chk("accept_timeout", FW'(0), FW'(1));
      else model_beat(d, s, l);
      @(posedge WClk);
      #1 bus.s_valid = 1'b0;
   endtask
   task automatic idle(input int n);
      bus.s_valid = 1'b0;
      repeat (n) @(posedge WClk);
      #1;
   endtask
   task automatic do_reset();
      #3 rstn = 1'b0;
      cur_d.delete();
      cur_s.delete();
      exp_q.delete();
      exp_words = '0;
      #1;
      chk("rst_busy", FW'(busy), FW'(0));
      chk("rst_ready", FW'(bus.s_ready), FW'(1));
      chk("rst_we", FW'(bus.fifo_we), FW'(0));
      chk("rst_d", bus.fifo_d, FW'(0));
      chk("rst_words", FW'(words_out), FW'(0));
      @(negedge WClk) rstn = 1'b1;
      @(posedge WClk);
      #1;
   endtask
   initial begin
      int st, tot;
      bit rand_done;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.s_strb = '0;
      bus.s_last = 1'b0;
      bus.fifo_wfull = 1'b0;
      #1;
      chk("init_ready", FW'(bus.s_ready), FW'(1));
      chk("init_we", FW'(bus.fifo_we), FW'(0));
      chk("init_d", bus.fifo_d, FW'(0));
      chk("init_words", FW'(words_out), FW'(0));
      chk("init_busy", FW'(busy), FW'(0));
      @(negedge WClk) rstn = 1'b1;
      @(posedge WClk);
      #1;
      for (int i = 1; i <= 4; i++) send_beat(IW'(32'h11111111 * i), 4'hF, i == 4, st);
      @(negedge WClk);
      chk("t1_latency_we", FW'(bus.fifo_we), FW'(1));
      chk("t1_word", bus.fifo_d, {1'b1, 16'hFFFF, 128'h44444444_33333333_22222222_11111111});
      idle(3);
      chk("t1_words", FW'(words_out), FW'(1));
      chk("t1_busy", FW'(busy), FW'(0));
      send_beat(32'hA, 4'hF, 1'b0, st);
      send_beat(32'hB, 4'hF, 1'b0, st);
      send_beat(32'hC, 4'hF, 1'b1, st);
      @(negedge WClk);
      chk("t2_word", bus.fifo_d, {1'b1, 16'h0FFF, 128'h00000000_0000000C_0000000B_0000000A});
      idle(3);
      wr_cyc.delete();
      tot = 0;
      for (int i = 0; i < 16; i++) begin
         send_beat($urandom, SW'($urandom), i % 4 == 3, st);
         tot += st;
      end
      idle(3);
      chk("t3_no_stall", FW'(tot), FW'(0));
      chk("t3_nwrites", FW'(wr_cyc.size()), FW'(4));
      for (int i = 1; i < 4 && i < wr_cyc.size(); i++)
         chk("t3_spacing", FW'(wr_cyc[i] - wr_cyc[i-1]), FW'(4));
      chk("t3_words", FW'(words_out), FW'(exp_words));
      bus.fifo_wfull = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) send_beat($urandom, 4'hF, i == 3, st);
            send_beat(32'hDEADBEEF, 4'h3, 1'b1, st);
         end
         begin
            repeat (10) begin
               @(negedge WClk);
               chk("t4_we_held", FW'(bus.fifo_we), FW'(0));
            end
            chk("t4_ready_hold", FW'(bus.s_ready), FW'(0));
            @(posedge WClk);
            #1 bus.fifo_wfull = 1'b0;
            @(negedge WClk);
            chk("t4_we_release", FW'(bus.fifo_we), FW'(1));
            chk("t4_ready_release", FW'(bus.s_ready), FW'(1));
         end
      join
      idle(3);
      chk("t4_words", FW'(words_out), FW'(exp_words));
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
               send_beat($urandom, SW'($urandom), $urandom_range(0, 5) == 0, st);
            end
            send_beat($urandom, SW'($urandom), 1'b1, st);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge WClk);
               #1 bus.fifo_wfull = ($urandom_range(0, 3) == 0);
            end
            bus.fifo_wfull = 1'b0;
         end
      join
      idle(4);
      chk("rand_drained", FW'(exp_q.size()), FW'(0));
      chk("rand_words", FW'(words_out), FW'(exp_words));
      send_beat(32'h55555555, 4'hF, 1'b0, st);
      send_beat(32'h66666666, 4'hF, 1'b0, st);
      chk("t5_busy_before", FW'(busy), FW'(1));
      do_reset();
      for (int i = 1; i <= 4; i++) send_beat(IW'(32'h01010101 * i), 4'hF, i == 4, st);
      @(negedge WClk);
      chk("t5_word", bus.fifo_d, {1'b1, 16'hFFFF, 128'h04040404_03030303_02020202_01010101});
      idle(3);
      chk("t5_words", FW'(words_out), FW'(1));
      do_reset();
      for (int i = 0; i < 65536; i++) send_beat($urandom, SW'($urandom_range(1, 15)), 1'b1, st);
      idle(3);
      chk("t6_drained", FW'(exp_q.size()), FW'(0));
      chk("t6_words_wrap", FW'(words_out), FW'(0));
      chk("t6_model_wrap", FW'(words_out), FW'(exp_words));
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
